// File: rtl/bcd_split_scheduler.sv
// Two-requester binary-to-BCD splitter.
// A 10-bit operand is taken from one requester at a time, with round-robin
// arbitration on a tie. It is split into hundreds/tens/ones by repeated
// subtraction, one subtraction per clock. Operands above 999 are flagged
// and return 9,9,9 without any subtraction.
module bcd_split_scheduler (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  input  logic [9:0] req0_value,
  output logic       req0_ack,
  input  logic       req1_valid,
  input  logic [9:0] req1_value,
  output logic       req1_ack,
  output logic       busy,
  output logic       resp_valid,
  output logic       resp_id,
  output logic [3:0] hundreds,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       err
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SUB100 = 2'd1,
    S_SUB10  = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  state_e     state_q;
  logic [9:0] rem_q;
  logic [3:0] hcnt_q;
  logic [3:0] tcnt_q;
  logic       grant_id_q;
  logic       last_served_q;
  logic       busy_q;
  logic       resp_valid_q;
  logic       resp_id_q;
  logic [3:0] hundreds_q;
  logic [3:0] tens_q;
  logic [3:0] ones_q;
  logic       err_q;

  logic       grant_sel_s;
  logic       accept_s;
  logic [9:0] acc_value_s;

  // Arbitration: a lone requester wins; on a tie the one not served last wins.
  always_comb begin
    grant_sel_s = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_sel_s = ~last_served_q;
    end else if (req1_valid) begin
      grant_sel_s = 1'b1;
    end else begin
      grant_sel_s = 1'b0;
    end
  end

  // Acks are only offered in IDLE and are held low while reset is asserted.
  assign accept_s    = rst_n && (state_q == S_IDLE) && (req0_valid || req1_valid);
  assign acc_value_s = grant_sel_s ? req1_value : req0_value;
  assign req0_ack    = accept_s && !grant_sel_s;
  assign req1_ack    = accept_s && grant_sel_s;

  // Conversion FSM together with its registered result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      rem_q         <= 10'd0;
      hcnt_q        <= 4'd0;
      tcnt_q        <= 4'd0;
      grant_id_q    <= 1'b0;
      last_served_q <= 1'b1;
      busy_q        <= 1'b0;
      resp_valid_q  <= 1'b0;
      resp_id_q     <= 1'b0;
      hundreds_q    <= 4'd0;
      tens_q        <= 4'd0;
      ones_q        <= 4'd0;
      err_q         <= 1'b0;
    end else begin
      resp_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept_s) begin
            last_served_q <= grant_sel_s;
            grant_id_q    <= grant_sel_s;
            rem_q         <= acc_value_s;
            hcnt_q        <= 4'd0;
            tcnt_q        <= 4'd0;
            busy_q        <= 1'b1;
            if (acc_value_s > 10'd999) begin
              // Out of range: answer immediately with a saturated 999.
              state_q      <= S_DONE;
              resp_valid_q <= 1'b1;
              resp_id_q    <= grant_sel_s;
              hundreds_q   <= 4'd9;
              tens_q       <= 4'd9;
              ones_q       <= 4'd9;
              err_q        <= 1'b1;
            end else begin
              state_q <= S_SUB100;
            end
          end else begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        S_SUB100: begin
          if (rem_q >= 10'd100) begin
            rem_q  <= rem_q - 10'd100;
            hcnt_q <= hcnt_q + 4'd1;
          end else begin
            state_q <= S_SUB10;
          end
        end
        S_SUB10: begin
          if (rem_q >= 10'd10) begin
            rem_q  <= rem_q - 10'd10;
            tcnt_q <= tcnt_q + 4'd1;
          end else begin
            // Remainder is now below 10, so its low nibble is the ones digit.
            state_q      <= S_DONE;
            resp_valid_q <= 1'b1;
            resp_id_q    <= grant_id_q;
            hundreds_q   <= hcnt_q;
            tens_q       <= tcnt_q;
            ones_q       <= rem_q[3:0];
            err_q        <= 1'b0;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy       = busy_q;
  assign resp_valid = resp_valid_q;
  assign resp_id    = resp_id_q;
  assign hundreds   = hundreds_q;
  assign tens       = tens_q;
  assign ones       = ones_q;
  assign err        = err_q;

endmodule

// File: tb/tb_bcd_split_scheduler.sv
// Self-checking bench for bcd_split_scheduler: directed steps plus random
// operands, compared against an arithmetic reference (div/mod digits,
// h+t+3 latency, round-robin on ties).
module tb_bcd_split_scheduler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0_valid = 1'b0;
  logic [9:0] req0_value = 10'd0;
  logic       req0_ack;
  logic       req1_valid = 1'b0;
  logic [9:0] req1_value = 10'd0;
  logic       req1_ack;
  logic       busy;
  logic       resp_valid;
  logic       resp_id;
  logic [3:0] hundreds;
  logic [3:0] tens;
  logic [3:0] ones;
  logic       err;

  int errors = 0;
  int checks = 0;
  int last_served = 1;

  bcd_split_scheduler dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_value (req0_value),
    .req0_ack   (req0_ack),
    .req1_valid (req1_valid),
    .req1_value (req1_value),
    .req1_ack   (req1_ack),
    .busy       (busy),
    .resp_valid (resp_valid),
    .resp_id    (resp_id),
    .hundreds   (hundreds),
    .tens       (tens),
    .ones       (ones),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic start(input int id, input logic [9:0] v);
    if (id == 0) begin
      req0_valid = 1'b1;
      req0_value = v;
    end else begin
      req1_valid = 1'b1;
      req1_value = v;
    end
  endtask

  // Wait (bounded) for the expected requester's ack; n = negedges waited.
  task automatic wait_ack(input int exp_id, output int n);
    bit got;
    logic own, other;
    n = 0;
    got = 1'b0;
    own = 1'b0;
    other = 1'b0;
    while (!got && n < 50) begin
      @(negedge clk);
      n++;
      own   = (exp_id == 0) ? req0_ack : req1_ack;
      other = (exp_id == 0) ? req1_ack : req0_ack;
      if (own) got = 1'b1;
    end
    check("ack_seen", 32'(got), 32'd1);
    check("ack_other_low", 32'(other), 32'd0);
    last_served = exp_id;
  endtask

  // Called at the ack negedge; follows the conversion to its response.
  task automatic finish_resp(input int id, input logic [9:0] v, input bit drop, input bit toggle);
    int lat, h, t, o, e, el;
    bit got;
    if (v > 10'd999) begin
      h = 9; t = 9; o = 9; e = 1; el = 1;
    end else begin
      h = int'(v) / 100;
      t = (int'(v) / 10) % 10;
      o = int'(v) % 10;
      e = 0;
      el = h + t + 3;
    end
    @(posedge clk);
    #1;
    if (drop) begin
      if (id == 0) req0_valid = 1'b0;
      else req1_valid = 1'b0;
    end
    if (toggle) begin
      if (id == 0) req1_valid = 1'b1;
      else req0_valid = 1'b1;
    end
    lat = 0;
    got = 1'b0;
    while (!got && lat < 40) begin
      @(negedge clk);
      lat++;
      if (lat == 1) check("busy_cycle1", 32'(busy), 32'd1);
      if (resp_valid) begin
        got = 1'b1;
      end else if (toggle) begin
        if (id == 0) req1_value = 10'($urandom_range(1023, 0));
        else req0_value = 10'($urandom_range(1023, 0));
      end
    end
    check("latency", 32'(lat), 32'(el));
    check("hundreds", 32'(hundreds), 32'(h));
    check("tens", 32'(tens), 32'(t));
    check("ones", 32'(ones), 32'(o));
    check("err", 32'(err), 32'(e));
    check("resp_id", 32'(resp_id), 32'(id));
    check("busy_at_resp", 32'(busy), 32'd1);
    @(posedge clk);
    #1;
    check("pulse_end", 32'(resp_valid), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    check("hold_hundreds", 32'(hundreds), 32'(h));
  endtask

  task automatic run_one(input int id, input logic [9:0] v);
    int n;
    start(id, v);
    wait_ack(id, n);
    finish_resp(id, v, 1'b1, 1'b0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_ack0"}, 32'(req0_ack), 32'd0);
    check({tag, "_ack1"}, 32'(req1_ack), 32'd0);
    check({tag, "_digits"}, {20'd0, hundreds, tens, ones}, 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
    check({tag, "_id"}, 32'(resp_id), 32'd0);
  endtask

  initial begin
    int n;
    int pulses;
    int exp_id;
    logic [9:0] bvals [8];
    logic [9:0] fin;
    bvals = '{10'd0, 10'd9, 10'd10, 10'd99, 10'd100, 10'd109, 10'd990, 10'd1000};

    // Power-on reset.
    #1;
    check_outputs_zero("por");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    last_served = 1;

    // Single requests.
    run_one(0, 10'd999);
    run_one(1, 10'd100);

    // Tie: both held valid, grants must alternate with back-to-back acks.
    req0_value = 10'd123;
    req1_value = 10'd456;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_id = 1 - last_served;
      wait_ack(exp_id, n);
      if (k > 0) check("tie_gap", 32'(n), 32'd1);
      finish_resp(exp_id, (exp_id == 0) ? 10'd123 : 10'd456, 1'b0, 1'b0);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    // Overflow.
    run_one(1, 10'd1023);
    run_one(0, 10'd1000);

    // Boundaries.
    for (int i = 0; i < 8; i++) run_one(i % 2, bvals[i]);

    // Stability: req0 value churns while req1 is served.
    start(1, 10'd789);
    wait_ack(1, n);
    finish_resp(1, 10'd789, 1'b1, 1'b1);
    fin = 10'd314;
    req0_value = fin;
    wait_ack(0, n);
    check("stab_gap", 32'(n), 32'd1);
    finish_resp(0, fin, 1'b1, 1'b0);

    // Random operands.
    for (int i = 0; i < 20; i++) begin
      run_one(int'($urandom_range(1, 0)), 10'($urandom_range(1023, 0)));
    end

    // Reset in the middle of converting 765.
    run_one(1, 10'd987);
    start(0, 10'd765);
    wait_ack(0, n);
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    repeat (5) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("midreset");
    last_served = 1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (resp_valid) pulses++;
    end
    check("no_resp_after_reset", 32'(pulses), 32'd0);
    run_one(0, 10'd5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bcd_split_scheduler.md
# bcd_split_scheduler

Sequential binary-to-BCD splitter shared by two requesters in the clock's display path, e.g. the year counter and the day/date counter. It accepts a 10-bit value from one requester at a time using round-robin arbitration. It produces hundreds, tens and ones digits by iterative subtract-by-100 then subtract-by-10, one subtraction per clock. It returns the digits, an error flag and the requester ID with a one-cycle valid pulse.

## Interface
- No parameters; all widths fixed.
- clk  in  1  system clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req0_valid  in  1  requester 0 has an operand pending
- req0_value  in  10  requester 0 operand
- req0_ack  out  1  requester 0 operand accepted this cycle
- req1_valid  in  1  requester 1 has an operand pending
- req1_value  in  10  requester 1 operand
- req1_ack  out  1  requester 1 operand accepted this cycle
- busy  out  1  high in every state except IDLE
- resp_valid  out  1  one-cycle pulse; digits/err/id valid
- resp_id  out  1  requester the response belongs to
- hundreds  out  4  BCD hundreds digit
- tens  out  4  BCD tens digit
- ones  out  4  BCD ones digit
- err  out  1  operand was > 999

## Operation
- States: IDLE, SUB100, SUB10, DONE.
- IDLE
  - When at least one reqN_valid is high, grant one requester.
  - reqN_ack is combinational: high only in IDLE for the granted requester.
  - On that edge the block latches the operand into a 10-bit remainder, clears the hundreds/tens counters and records grant_id.
  - Next state is SUB100.
- Arbitration
  - If only one requester is valid, grant it.
  - If both are valid, grant the one not served last.
  - The last-served register resets to 1, so requester 0 wins the first tie.
- Overflow
  - An accepted operand > 999 (1000..1023) skips subtraction and goes directly to DONE.
  - It returns err=1 with digits 9,9,9.
- SUB100
  - If remainder ≥ 100: remainder -= 100 and hundreds += 1; stay in SUB100.
  - Otherwise go to SUB10.
- SUB10
  - If remainder ≥ 10: remainder -= 10 and tens += 1; stay in SUB10.
  - Otherwise go to DONE.
- DONE
  - Register hundreds, tens, ones (= remainder[3:0]), err and resp_id to the outputs.
  - Pulse resp_valid for exactly one cycle, then go to IDLE.
- Outputs hundreds/tens/ones/err/resp_id hold their last values until the next DONE.
- Digits never exceed 9; the internal counters are 4-bit and cannot wrap for legal inputs.
- Requesters must hold reqN_valid and reqN_value stable until they see reqN_ack. The value is sampled only on the ack edge.
- reqN_valid changes during SUB100/SUB10/DONE have no effect until the block returns to IDLE.
- Reset
  - Asynchronous and effective immediately; takes priority over everything.
  - State → IDLE.
  - Outputs: resp_valid, busy, req0_ack, req1_ack, hundreds, tens, ones, err and resp_id all 0.
  - Last-served register → 1.
  - Any in-flight conversion is abandoned with no response.

## Timing
- The accept (ack) cycle is cycle 0. For a legal operand with digits h,t,o, resp_valid is high in cycle h+t+3.
  - Cycles 1..h: subtract-100.
  - Cycle h+1: move to SUB10.
  - Cycles h+2..h+t+1: subtract-10.
  - Cycle h+t+2: move to DONE, with outputs registered on that edge.
- Minimum latency: 3 cycles (operand 0).
- Maximum latency: 21 cycles (999).
- Overflow latency: resp_valid in cycle 1.
- busy is high from cycle 1 through the resp_valid cycle, inclusive.
- The earliest next ack is the cycle after resp_valid (IDLE). Back-to-back throughput is one conversion per latency+1 cycles.
- No output is combinational from the request inputs except reqN_ack.

## Test plan
- Reset
  - Stimulus: assert rst_n=0 mid-conversion of 765.
  - Required: all outputs 0 immediately and no resp_valid afterwards.
  - Then 0 → 1 and req0 value 5: resp_valid at cycle 3 with 0,0,5.
- Single requests
  - Stimulus: req0 value 999.
  - Required: ack at cycle 0; resp_valid at cycle 21 with 9,9,9, err=0, resp_id=0.
  - Stimulus: req1 value 100.
  - Required: resp_valid at cycle 4 with 1,0,0 and resp_id=1.
- Tie round-robin
  - Stimulus: both valid continuously, with values 123 (req0) and 456 (req1).
  - Required: grants alternate 0,1,0,1.
  - Responses 1,2,3 and 4,5,6 with matching resp_id.
  - Each new ack arrives exactly one cycle after the previous resp_valid.
- Overflow
  - Stimulus: req1 value 1023.
  - Required: resp_valid at cycle 1 with err=1, digits 9,9,9.
  - Stimulus: next request value 1000.
  - Required: same result.
- Boundaries
  - Stimulus: run operands 0, 9, 10, 99, 100, 109, 990 and 1000 in sequence.
  - Required: correct digits each time, and latency equals h+t+3 for every legal operand.
- Stability
  - Stimulus: toggle req0_value while the block is busy serving req1.
  - Required: req1's result is unaffected; req0's value is sampled only on its ack edge.
